// File: rtl/pll_gain_scheduler.sv
// Multi-gear PLL loop-filter gain scheduler: acquisition gain on sustained unlock,
// one gear step-down per locked dwell until the tracking gear is reached.
module pll_gain_scheduler #(
    parameter int GAIN_W    = 5,
    parameter int TIMER_W   = 8,
    parameter int NUM_GEARS = 4,
    parameter int GEAR_W    = $clog2(NUM_GEARS)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic                lock_in,
    input  logic                force_acq,
    input  logic [GAIN_W-1:0]   kp_track,
    input  logic [GAIN_W-1:0]   ki_track,
    input  logic [GAIN_W-1:0]   kp_step,
    input  logic [GAIN_W-1:0]   ki_step,
    input  logic [TIMER_W-1:0]  unlock_timeout,
    input  logic [TIMER_W-1:0]  dwell_cycles,
    output logic [GAIN_W-1:0]   kp_shift,
    output logic [GAIN_W-1:0]   ki_shift,
    output logic [GEAR_W-1:0]   gear,
    output logic [1:0]          state,
    output logic                acq_active,
    output logic                gear_change
);

    typedef enum logic [1:0] {
        TRACK   = 2'd0,
        HOLDOFF = 2'd1,
        ACQUIRE = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int                SUM_W    = GAIN_W + GEAR_W + 1;
    localparam int                CNT_W    = TIMER_W + 1;
    localparam logic [GEAR_W-1:0] ACQ_GEAR = GEAR_W'(NUM_GEARS - 1);
    localparam logic [SUM_W-1:0]  GAIN_MAX = SUM_W'((1 << GAIN_W) - 1);

    state_t              state_q, state_d;
    logic [GEAR_W-1:0]   gear_q, gear_d;
    logic [TIMER_W-1:0]  hold_q, hold_d;
    logic [TIMER_W-1:0]  dwell_q, dwell_d;
    logic [TIMER_W-1:0]  dwell_lim;
    logic [CNT_W-1:0]    dwell_inc;

    // Wide enough that track + gear*step cannot wrap before saturation.
    function automatic logic [GAIN_W-1:0] sat_gain(
        input logic [GAIN_W-1:0] base,
        input logic [GAIN_W-1:0] step,
        input logic [GEAR_W-1:0] g
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(g) * SUM_W'(step);
        return (sum > GAIN_MAX) ? '1 : sum[GAIN_W-1:0];
    endfunction

    assign dwell_lim  = (dwell_cycles == '0) ? TIMER_W'(1) : dwell_cycles;
    assign dwell_inc  = {1'b0, dwell_q} + CNT_W'(1);
    assign state      = state_q;
    assign gear       = gear_q;
    assign acq_active = (state_q == ACQUIRE);

    always_comb begin
        state_d = state_q;
        gear_d  = gear_q;
        hold_d  = hold_q;
        dwell_d = dwell_q;
        if (force_acq) begin
            state_d = ACQUIRE;
            gear_d  = ACQ_GEAR;
            hold_d  = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                TRACK: begin
                    if (!lock_in) begin
                        state_d = HOLDOFF;
                        hold_d  = '0;
                    end
                end
                HOLDOFF: begin
                    if (lock_in) begin
                        hold_d = '0;
                        if (gear_q == '0) begin
                            state_d = TRACK;
                        end else begin
                            state_d = SETTLE;
                            dwell_d = '0;
                        end
                    end else if (hold_q == unlock_timeout) begin
                        state_d = ACQUIRE;
                        gear_d  = ACQ_GEAR;
                        hold_d  = '0;
                    end else if (sample_en) begin
                        hold_d = hold_q + TIMER_W'(1);
                    end
                end
                ACQUIRE: begin
                    if (lock_in) begin
                        state_d = SETTLE;
                        dwell_d = '0;
                    end
                end
                SETTLE: begin
                    // Lock loss is tested first so it wins over a coincident dwell expiry.
                    if (!lock_in) begin
                        state_d = HOLDOFF;
                        hold_d  = '0;
                        dwell_d = '0;
                    end else if (sample_en) begin
                        if (dwell_inc >= {1'b0, dwell_lim}) begin
                            gear_d  = gear_q - GEAR_W'(1);
                            dwell_d = '0;
                            if (gear_q == GEAR_W'(1)) begin
                                state_d = TRACK;
                            end
                        end else begin
                            dwell_d = dwell_inc[TIMER_W-1:0];
                        end
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ACQUIRE;
            gear_q      <= ACQ_GEAR;
            hold_q      <= '0;
            dwell_q     <= '0;
            gear_change <= 1'b0;
            kp_shift    <= sat_gain(kp_track, kp_step, ACQ_GEAR);
            ki_shift    <= sat_gain(ki_track, ki_step, ACQ_GEAR);
        end else begin
            state_q     <= state_d;
            gear_q      <= gear_d;
            hold_q      <= hold_d;
            dwell_q     <= dwell_d;
            gear_change <= (gear_d != gear_q);
            kp_shift    <= sat_gain(kp_track, kp_step, gear_d);
            ki_shift    <= sat_gain(ki_track, ki_step, gear_d);
        end
    end

endmodule

// File: tb/tb_pll_gain_scheduler.sv
// Bench for pll_gain_scheduler: per-cycle model comparison plus directed
// scenario checks with hand-computed values.
module tb_pll_gain_scheduler;

    localparam int GAIN_W  = 5;
    localparam int TIMER_W = 8;
    localparam int NG      = 4;
    localparam int GEAR_W  = 2;
    localparam int S_TRACK = 0, S_HOLD = 1, S_ACQ = 2, S_SETTLE = 3;

    logic                sys_clk = 1'b0;
    logic                rst, sample_en, lock_in, force_acq;
    logic [GAIN_W-1:0]   kp_track, ki_track, kp_step, ki_step;
    logic [TIMER_W-1:0]  unlock_timeout, dwell_cycles;
    logic [GAIN_W-1:0]   kp_shift, ki_shift;
    logic [GEAR_W-1:0]   gear;
    logic [1:0]          state;
    logic                acq_active, gear_change;

    pll_gain_scheduler #(
        .GAIN_W(GAIN_W), .TIMER_W(TIMER_W), .NUM_GEARS(NG)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .sample_en(sample_en), .lock_in(lock_in),
        .force_acq(force_acq), .kp_track(kp_track), .ki_track(ki_track),
        .kp_step(kp_step), .ki_step(ki_step), .unlock_timeout(unlock_timeout),
        .dwell_cycles(dwell_cycles), .kp_shift(kp_shift), .ki_shift(ki_shift),
        .gear(gear), .state(state), .acq_active(acq_active), .gear_change(gear_change)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: ints holding what the spec says each output must be.
    int ms, mg, mh, md, mgc, mkp, mki;
    bit m_valid = 1'b0;

    function automatic int gain_of(input int base, input int step, input int g);
        int v;
        v = base + g * step;
        return (v > (1 << GAIN_W) - 1) ? (1 << GAIN_W) - 1 : v;
    endfunction

    always @(posedge sys_clk) begin
        int prev, lim;
        if (rst) begin
            ms = S_ACQ; mg = NG - 1; mh = 0; md = 0; mgc = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            prev = mg;
            lim  = (int'(dwell_cycles) == 0) ? 1 : int'(dwell_cycles);
            if (force_acq) begin
                ms = S_ACQ; mg = NG - 1; mh = 0; md = 0;
            end else if (ms == S_TRACK) begin
                if (!lock_in) begin ms = S_HOLD; mh = 0; end
            end else if (ms == S_HOLD) begin
                if (lock_in) begin
                    mh = 0;
                    if (mg == 0) ms = S_TRACK;
                    else begin ms = S_SETTLE; md = 0; end
                end else if (mh == int'(unlock_timeout)) begin
                    ms = S_ACQ; mg = NG - 1; mh = 0;
                end else if (sample_en) begin
                    mh = mh + 1;
                end
            end else if (ms == S_ACQ) begin
                if (lock_in) begin ms = S_SETTLE; md = 0; end
            end else begin
                if (!lock_in) begin
                    ms = S_HOLD; md = 0; mh = 0;
                end else if (sample_en) begin
                    md = md + 1;
                    if (md >= lim) begin
                        mg = mg - 1; md = 0;
                        if (mg == 0) ms = S_TRACK;
                    end
                end
            end
            mgc = (mg != prev) ? 1 : 0;
        end
        mkp = gain_of(int'(kp_track), int'(kp_step), mg);
        mki = gain_of(int'(ki_track), int'(ki_step), mg);
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("m_state", int'(state), ms);
            chk("m_gear", int'(gear), mg);
            chk("m_kp_shift", int'(kp_shift), mkp);
            chk("m_ki_shift", int'(ki_shift), mki);
            chk("m_gear_change", int'(gear_change), mgc);
            chk("m_acq_active", int'(acq_active), (ms == S_ACQ) ? 1 : 0);
        end
    end

    int n_samp, n_gc, c;
    int kp_hist [8];

    task automatic cyc(input bit se);
        sample_en = se;
        @(posedge sys_clk);
        if (se) n_samp++;
        @(negedge sys_clk);
        if (gear_change) n_gc++;
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; lock_in = 1'b0; force_acq = 1'b0;
        kp_track = 5'd13; ki_track = 5'd9; kp_step = 5'd2; ki_step = 5'd2;
        unlock_timeout = 8'd32; dwell_cycles = 8'd4;
        cyc(0); cyc(0);
        rst = 1'b0;
        chk("rst_state", int'(state), S_ACQ);
        chk("rst_gear", int'(gear), 3);
        chk("rst_kp", int'(kp_shift), 19);
        chk("rst_ki", int'(ki_shift), 15);
        chk("rst_gc", int'(gear_change), 0);
        chk("rst_acq_active", int'(acq_active), 1);

        // Step-down 3->2->1->0, sample every third cycle, dwell 4.
        lock_in = 1'b1; n_samp = 0; n_gc = 0;
        cyc(0);
        chk("settle_entry", int'(state), S_SETTLE);
        for (int i = 1; i < 60; i++) begin
            cyc((i % 3) == 2);
            if (gear_change && n_gc <= 8) kp_hist[n_gc-1] = int'(kp_shift);
            if (state == 2'(S_TRACK)) break;
        end
        chk("step_track", int'(state), S_TRACK);
        chk("step_samples", n_samp, 12);
        chk("step_pulses", n_gc, 3);
        chk("step_kp_g2", kp_hist[0], 17);
        chk("step_kp_g1", kp_hist[1], 15);
        chk("step_kp_g0", kp_hist[2], 13);
        chk("step_ki_g0", int'(ki_shift), 9);

        // Brief unlock inside holdoff, then a full timeout.
        n_gc = 0; lock_in = 1'b0;
        cyc(1);
        chk("holdoff_entry", int'(state), S_HOLD);
        repeat (19) cyc(1);
        chk("holdoff_20", int'(state), S_HOLD);
        lock_in = 1'b1;
        cyc(0);
        chk("holdoff_back", int'(state), S_TRACK);
        chk("holdoff_gear", int'(gear), 0);
        chk("holdoff_nogc", n_gc, 0);
        lock_in = 1'b0; c = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1);
            c = i;
            if (state == 2'(S_ACQ)) break;
        end
        chk("timeout_cycles", c, 34);
        chk("timeout_gear", int'(gear), 3);
        chk("timeout_pulses", n_gc, 1);
        chk("timeout_kp", int'(kp_shift), 19);

        // Saturation at both ends of the gear range.
        kp_track = 5'd30; ki_track = 5'd31;
        cyc(0);
        chk("sat_kp_g3", int'(kp_shift), 31);
        chk("sat_ki_g3", int'(ki_shift), 31);
        dwell_cycles = 8'd1; lock_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (state == 2'(S_TRACK)) break;
        end
        chk("sat_track", int'(state), S_TRACK);
        chk("sat_kp_g0", int'(kp_shift), 30);
        chk("sat_ki_g0", int'(ki_shift), 31);

        // force_acq pulse, then dwell expiry coinciding with lock loss.
        kp_track = 5'd13; ki_track = 5'd9; dwell_cycles = 8'd4;
        cyc(0);
        n_gc = 0; force_acq = 1'b1;
        cyc(0);
        chk("force_state", int'(state), S_ACQ);
        chk("force_gear", int'(gear), 3);
        chk("force_pulse", n_gc, 1);
        force_acq = 1'b0;
        cyc(0);
        chk("force_settle", int'(state), S_SETTLE);
        repeat (4) cyc(1);
        chk("race_g2", int'(gear), 2);
        repeat (3) cyc(1);
        lock_in = 1'b0; n_gc = 0;
        cyc(1);
        chk("race_state", int'(state), S_HOLD);
        chk("race_gear", int'(gear), 2);
        chk("race_nogc", n_gc, 0);
        lock_in = 1'b1;
        cyc(0);
        chk("race_resettle", int'(state), S_SETTLE);
        repeat (3) cyc(1);
        chk("race_dwell_restart", int'(gear), 2);
        cyc(1);
        chk("race_step", int'(gear), 1);

        // Reset in the middle of a dwell.
        repeat (2) cyc(1);
        rst = 1'b1;
        cyc(0);
        rst = 1'b0;
        chk("midrst_state", int'(state), S_ACQ);
        chk("midrst_gear", int'(gear), 3);
        chk("midrst_kp", int'(kp_shift), 19);
        chk("midrst_gc", int'(gear_change), 0);
        cyc(0);
        repeat (3) cyc(1);
        chk("midrst_dwell0", int'(gear), 3);
        cyc(1);
        chk("midrst_step", int'(gear), 2);

        // Zero holdoff timeout.
        unlock_timeout = 8'd0; lock_in = 1'b0;
        cyc(0);
        chk("t0_hold", int'(state), S_HOLD);
        cyc(0);
        chk("t0_acq", int'(state), S_ACQ);
        chk("t0_gear", int'(gear), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_gain_scheduler.md
Name: pll_gain_scheduler

Overview:
- Parametrised successor to the two-level PLL gain switch.
- Drives `kp_shift`/`ki_shift` of the loop filter from a multi-gear schedule:
  - full acquisition gain on a real unlock, after a programmable hysteresis timeout;
  - steps down one gear per programmable locked dwell until tracking gear 0.
- Sits between the loop filter's `lock_detect` and its gain inputs, clocked by `sys_clk`, qualified by the PFD `sample_en` strobe.

Parameters:
- GAIN_W, 5, width of shift-gain inputs and outputs.
- TIMER_W, 8, width of holdoff/dwell counters and their limit inputs.
- NUM_GEARS, 4, number of gears (>=2); gear 0 = tracking, gear NUM_GEARS-1 = acquisition.
- GEAR_W, $clog2(NUM_GEARS), width of the gear output.

Ports:
- sys_clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- sample_en  in  1  PFD sample strobe; the only event that advances the counters.
- lock_in  in  1  lock indication from the loop filter.
- force_acq  in  1  level; forces acquisition gear while high.
- kp_track  in  GAIN_W  gear-0 proportional shift.
- ki_track  in  GAIN_W  gear-0 integral shift.
- kp_step  in  GAIN_W  kp added per gear.
- ki_step  in  GAIN_W  ki added per gear.
- unlock_timeout  in  TIMER_W  unlocked samples tolerated before acquisition.
- dwell_cycles  in  TIMER_W  locked samples per gear step-down (0 treated as 1).
- kp_shift  out  GAIN_W  registered proportional shift.
- ki_shift  out  GAIN_W  registered integral shift.
- gear  out  GEAR_W  current gear.
- state  out  2  TRACK=0, HOLDOFF=1, ACQUIRE=2, SETTLE=3.
- acq_active  out  1  high when state==ACQUIRE.
- gear_change  out  1  one-cycle pulse on every gear change.

Behaviour:
- Reset (rst high at an edge):
  - state=ACQUIRE, gear=NUM_GEARS-1, both counters=0, gear_change=0.
  - kp_shift/ki_shift = acquisition-gear gains computed from the config inputs at that edge.
- Gain arithmetic, every cycle:
  - kp_shift <= sat(kp_track + gear_next*kp_step); same form for ki_shift.
  - Computed at GAIN_W+GEAR_W+1 bits, saturated to 2^GAIN_W-1.
  - Gains change on the same edge as gear. Config changes take effect one cycle later.
- Priority: rst > force_acq > state transitions.
- force_acq high:
  - next state ACQUIRE, gear=NUM_GEARS-1, counters cleared.
  - gear_change pulses only if gear actually changed.
  - Remains in ACQUIRE while high, regardless of lock_in.
- TRACK (gear 0):
  - lock_in low on any cycle -> HOLDOFF; holdoff counter=0; gear held.
- HOLDOFF:
  - lock_in high -> return to TRACK if gear==0, else SETTLE with dwell counter=0; holdoff counter cleared.
  - Else, each sample_en increments the holdoff counter.
  - When counter==unlock_timeout (checked every cycle) -> ACQUIRE, gear=NUM_GEARS-1.
  - unlock_timeout=0: ACQUIRE on the cycle after entering HOLDOFF.
  - Counter never exceeds unlock_timeout.
- ACQUIRE:
  - lock_in high (force_acq low) -> SETTLE, dwell counter=0.
  - No counting in ACQUIRE.
- SETTLE:
  - lock_in low -> HOLDOFF, current gear held, dwell counter cleared.
  - Else, each sample_en increments the dwell counter.
  - When it reaches max(dwell_cycles,1): gear decrements, dwell counter clears, gear_change pulses.
  - If the new gear is 0 -> TRACK.
- Simultaneous events:
  - sample_en with lock_in low in SETTLE: leave to HOLDOFF; no dwell increment, no holdoff increment that cycle.
  - Dwell expiry and lock loss on the same cycle: lock loss wins, gear not decremented.
- Output timing:
  - acq_active is combinational from the state register.
  - gear_change is registered and aligned with the new gear value.
- rst mid-transition discards both counters and any in-progress step-down.

Test Plan:
- Reset, defaults, kp_track=13, ki_track=9, kp_step=ki_step=2, lock_in=0 -> state=2, gear=3, kp_shift=19, ki_shift=15, gear_change=0.
- From ACQUIRE: lock_in=1, dwell_cycles=4, sample_en every 3rd cycle -> SETTLE; gear steps 3->2->1->0 every 4 samples; kp_shift 19->17->15->13; three gear_change pulses; state=TRACK after the 12th sample.
- In TRACK, unlock_timeout=32: lock_in low for 20 samples then high -> HOLDOFF then TRACK; gear stays 0; no gear_change. Held low 32 samples -> ACQUIRE, gear=3, one pulse.
- Saturation: kp_track=30, kp_step=2, ki_track=31 -> gear 3 kp_shift=31, ki_shift=31; gear 0 kp_shift=30.
- In SETTLE at gear 2: lock_in drops on the same cycle dwell expires -> HOLDOFF, gear stays 2. Lock returns -> SETTLE, dwell restarts from 0.
- force_acq pulse in TRACK -> next cycle ACQUIRE, gear=3, one gear_change. rst asserted mid-SETTLE -> ACQUIRE, gear=3, counters 0.
